// File: rtl/fwd_hazard_unit.sv
// Forwarding/hazard unit for the MIPS Ex stage: tracks DEPTH in-flight writes,
// selects forwarding sources, stalls on load-use; long-op scoreboard under FWD_LONG_OP_EN.
module fwd_hazard_unit #(
  parameter  int REG_AW  = 5,
  parameter  int NSRC    = 2,
  parameter  int DEPTH   = 3,
  parameter  int MAX_LAT = 8,
  localparam int SEL_W   = $clog2(DEPTH + 2),
  localparam int CNT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  input  logic                    flush,
  input  logic [NSRC*REG_AW-1:0]  ex_src,
  input  logic [REG_AW-1:0]       ex_rd,
  input  logic                    ex_regwr,
  input  logic                    ex_load,
  input  logic                    ex_long,
  input  logic [CNT_W-1:0]        ex_lat,
  output logic [NSRC*SEL_W-1:0]   fwd_sel,
  output logic                    stall,
  output logic                    long_busy,
  output logic                    long_done,
  output logic [REG_AW-1:0]       long_rd
);

  logic              v_q    [1:DEPTH];
  logic              v_d    [1:DEPTH];
  logic [REG_AW-1:0] rd_q   [1:DEPTH];
  logic [REG_AW-1:0] rd_d   [1:DEPTH];
  logic              load_q [1:DEPTH];
  logic              load_d [1:DEPTH];

  logic [REG_AW-1:0] src [NSRC];
  logic [SEL_W-1:0]  sel [NSRC];
  logic              load_use;
  logic              long_dep;
  logic              waw;
  logic              structural;
  logic              accept;
  logic              is_long;
  logic              long_pend;

`ifdef FWD_LONG_OP_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] lrd_q, lrd_d;

  assign is_long   = ex_long;
  assign long_pend = (cnt_q > CNT_W'(1));
  assign long_done = (cnt_q == CNT_W'(1));
  assign long_busy = (cnt_q != '0);
  assign long_rd   = lrd_q;

  // A new accepted long op reloads the counter even in its predecessor's done cycle.
  always_comb begin
    cnt_d = cnt_q;
    lrd_d = lrd_q;
    if (accept && ex_long && ex_regwr && (ex_rd != '0)) begin
      cnt_d = (ex_lat == '0) ? CNT_W'(1) : ex_lat;
      lrd_d = ex_rd;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lrd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lrd_q <= lrd_d;
    end
  end
`else
  logic unused_long;

  assign unused_long = ^{ex_long, ex_lat};
  assign is_long     = 1'b0;
  assign long_pend   = 1'b0;
  assign long_done   = 1'b0;
  assign long_busy   = 1'b0;
  assign long_rd     = '0;
`endif

  // Scanning from the oldest stage down lets the youngest match overwrite older ones.
  always_comb begin
    fwd_sel    = '0;
    load_use   = 1'b0;
    long_dep   = 1'b0;
    waw        = long_pend && ex_regwr && (ex_rd == long_rd);
    structural = long_pend && ex_long;
    for (int i = 0; i < NSRC; i++) begin
      src[i] = ex_src[i*REG_AW +: REG_AW];
      sel[i] = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (v_q[k] && (rd_q[k] == src[i]) && (src[i] != '0))
          sel[i] = SEL_W'(k);
      end
      if (long_done && (long_rd == src[i]) && (src[i] != '0))
        sel[i] = SEL_W'(DEPTH + 1);
      if ((sel[i] == SEL_W'(1)) && load_q[1])
        load_use = 1'b1;
      if (long_pend && (src[i] == long_rd) && (src[i] != '0))
        long_dep = 1'b1;
      fwd_sel[i*SEL_W +: SEL_W] = sel[i];
    end
    stall  = ex_valid && !flush && (load_use || long_dep || waw || structural);
    accept = ex_valid && !stall && !flush;
  end

  always_comb begin
    v_d[1]    = accept && ex_regwr && (ex_rd != '0) && !is_long;
    rd_d[1]   = ex_rd;
    load_d[1] = ex_load;
    for (int k = 2; k <= DEPTH; k++) begin
      v_d[k]    = v_q[k-1];
      rd_d[k]   = rd_q[k-1];
      load_d[k] = load_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_q[k]    <= 1'b0;
        rd_q[k]   <= '0;
        load_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_q[k]    <= v_d[k];
        rd_q[k]   <= rd_d[k];
        load_q[k] <= load_d[k];
      end
    end
  end

endmodule
